disp_owner_arb: RTL and testbench

Round-robin owner arbiter for the shared 4-digit seven-segment display. Up to NREQ requesters each present four active-low segment bytes. The block grants the display to one requester at a time, enforces a minimum dwell per owner and inserts a blanking gap at every handover. Its registered d3..d0 outputs drive the in3..in0 inputs of the display multiplexer.

---
 rtl/disp_pkg.sv | 17 +
 rtl/rr_pick.sv | 33 +++
 rtl/disp_owner_arb.sv | 171 +++++++++++++++++
 tb/tb_disp_owner_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment display owner arbiter.
package disp_pkg;

    // Arbiter control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        OWN   = 2'd2
    } arb_state_t;

    // One active-low segment byte: {dp,g,f,e,d,c,b,a}.
    typedef logic [7:0] seg_t;

    // All segments off (active-low).
    localparam seg_t SEG_OFF = 8'hFF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set bit of vec at or
// after start, wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         vec,
    input  logic [$clog2(N)-1:0] start,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int          IW = $clog2(N);
    localparam int unsigned NU = N;

    // Scan every position once, starting at start, and keep the first hit.
    always_comb begin
        int unsigned      j;
        logic [IW-1:0]    jj;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        jj    = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            j  = (32'(start) + i) % NU;
            jj = IW'(j);
            if (!found && vec[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
    end

endmodule

// File: rtl/disp_owner_arb.sv
// Round-robin owner arbiter for the shared 4-digit seven-segment display.
// Grants the display to one requester at a time with a minimum dwell per
// owner and an all-off blanking gap at every handover. All outputs are
// registered.
// Optional feature: define DISP_ARB_LOCK_EN to add the per-requester lock
// input, which lets the current owner suppress preemption.
module disp_owner_arb
    import disp_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DWELL     = 100_000_000,
    parameter int BLANK_CYC = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*32-1:0]      din,
`ifdef DISP_ARB_LOCK_EN
    input  logic [NREQ-1:0]         lock,
`endif
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output seg_t                    d3,
    output seg_t                    d2,
    output seg_t                    d1,
    output seg_t                    d0
);

    localparam int          OW = $clog2(NREQ);
    localparam int          DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int          BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int unsigned NU = NREQ;

    arb_state_t       state;
    logic [OW-1:0]    rr_ptr;
    logic [DW-1:0]    dwell_cnt;
    logic [BW-1:0]    blank_cnt;

    logic [OW-1:0]    owner_nxt;
    logic [NREQ-1:0]  pick_vec;
    logic [OW-1:0]    pick_start;
    logic             pick_found;
    logic [OW-1:0]    pick_idx;
    logic [31:0]      own_din;
    logic             hold;

    // Successor index of the current owner, wrapping NREQ-1 to 0.
    always_comb begin
        owner_nxt = (owner == OW'(NREQ - 1)) ? '0 : owner + 1'b1;
    end

    // One shared picker: IDLE searches the full request vector from rr_ptr;
    // BLANK/OWN search from owner+1 with the owner masked out, which both
    // prevents self-selection on preemption and is a no-op when the owner
    // has already dropped its request.
    always_comb begin
        if (state == IDLE) begin
            pick_vec   = req;
            pick_start = rr_ptr;
        end else begin
            pick_vec   = req & ~(NREQ'(1) << owner);
            pick_start = owner_nxt;
        end
    end

    rr_pick #(.N(NREQ)) u_pick (
        .vec   (pick_vec),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Select the owner's 32-bit digit word.
    always_comb begin
        own_din = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            if (owner == OW'(k)) begin
                own_din = din[32*k +: 32];
            end
        end
    end

    // Owner lock: suppresses preemption only; release on req drop still wins.
`ifdef DISP_ARB_LOCK_EN
    always_comb begin
        hold = lock[owner];
    end
`else
    always_comb begin
        hold = 1'b0;
    end
`endif

    // Arbiter FSM with registered grant, owner and segment outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            dwell_cnt <= '0;
            blank_cnt <= '0;
            gnt       <= '0;
            d3        <= SEG_OFF;
            d2        <= SEG_OFF;
            d1        <= SEG_OFF;
            d0        <= SEG_OFF;
        end else begin
            case (state)
                IDLE: begin
                    gnt <= '0;
                    d3  <= SEG_OFF;
                    d2  <= SEG_OFF;
                    d1  <= SEG_OFF;
                    d0  <= SEG_OFF;
                    if (pick_found) begin
                        owner     <= pick_idx;
                        blank_cnt <= BW'(BLANK_CYC - 1);
                        state     <= BLANK;
                    end
                end
                BLANK: begin
                    gnt <= '0;
                    d3  <= SEG_OFF;
                    d2  <= SEG_OFF;
                    d1  <= SEG_OFF;
                    d0  <= SEG_OFF;
                    if (blank_cnt != '0) begin
                        blank_cnt <= blank_cnt - 1'b1;
                    end else if (req[owner]) begin
                        state     <= OWN;
                        gnt       <= NREQ'(1) << owner;
                        dwell_cnt <= DW'(DWELL - 1);
                        {d3, d2, d1, d0} <= own_din;
                    end else if (pick_found) begin
                        owner     <= pick_idx;
                        blank_cnt <= BW'(BLANK_CYC - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
                OWN: begin
                    if (!req[owner] || (dwell_cnt == '0 && pick_found && !hold)) begin
                        // Release and preemption share the handover path.
                        rr_ptr <= owner_nxt;
                        gnt    <= '0;
                        d3     <= SEG_OFF;
                        d2     <= SEG_OFF;
                        d1     <= SEG_OFF;
                        d0     <= SEG_OFF;
                        if (pick_found) begin
                            owner     <= pick_idx;
                            blank_cnt <= BW'(BLANK_CYC - 1);
                            state     <= BLANK;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        {d3, d2, d1, d0} <= own_din;
                        if (dwell_cnt != '0) begin
                            dwell_cnt <= dwell_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_owner_arb.sv
// Scoreboard bench for disp_owner_arb (NREQ=4, DWELL=8, BLANK_CYC=2).
// Define DISP_ARB_LOCK_EN for both RTL and bench to exercise the lock input.
module tb_disp_owner_arb;

    typedef struct packed {
        logic [3:0]  gnt;
        logic [1:0]  owner;
        logic        chk_owner;
        logic [31:0] d;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic [3:0]   req;
    logic [127:0] din;
`ifdef DISP_ARB_LOCK_EN
    logic [3:0]   lock;
`endif
    logic [3:0]   gnt;
    logic [1:0]   owner;
    logic [7:0]   d3, d2, d1, d0;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t e;

    disp_owner_arb #(
        .NREQ      (4),
        .DWELL     (8),
        .BLANK_CYC (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .din     (din),
`ifdef DISP_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .owner   (owner),
        .d3      (d3),
        .d2      (d2),
        .d1      (d1),
        .d0      (d0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] g, input logic [1:0] o,
                                input logic co, input logic [31:0] d);
        exp_t x;
        x.gnt = g; x.owner = o; x.chk_owner = co; x.d = d;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        for (int i = 0; i < 23; i++) begin
            if (i == 3) reset_n = 1'b1;
            exp_q.push_back(mk(4'b0000, 2'd0, 1'b1, 32'hFFFF_FFFF));
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (gnt !== e.gnt || {d3, d2, d1, d0} !== e.d || (e.chk_owner && owner !== e.owner)) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got gnt=%b d=%h owner=%0d, want gnt=%b d=%h owner=%0d",
                         i, gnt, {d3, d2, d1, d0}, owner, e.gnt, e.d, e.owner);
            end
        end
    endtask

    task automatic test_first_grant();
        din[95:64] = 32'hC0F9A4B0;
        req = 4'b0100;
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) exp_q.push_back(mk(4'b0000, 2'd2, 1'b1, 32'hFFFF_FFFF));
            else       exp_q.push_back(mk(4'b0100, 2'd2, 1'b1, 32'hC0F9A4B0));
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (gnt !== e.gnt || {d3, d2, d1, d0} !== e.d || (e.chk_owner && owner !== e.owner)) begin
                n_fail++;
                $display("FAIL first_grant edge %0d: got gnt=%b d=%h owner=%0d, want gnt=%b d=%h owner=%0d",
                         i, gnt, {d3, d2, d1, d0}, owner, e.gnt, e.d, e.owner);
            end
        end
    endtask

    // Two dwell-expiry preemptions: 2 -> 0 -> 1, with owner digits changing
    // every cycle to check the one-cycle din-to-d* path.
    task automatic test_preempt();
        int cur, nxt;
        req = 4'b0111;
        cur = 2;
        for (int r = 0; r < 2; r++) begin
            nxt = (r == 0) ? 0 : 1;
            for (int k = 0; k < 11; k++) begin
                if (k < 7) begin
                    din[32*cur +: 32] = $urandom;
                    din[32*3 +: 32]   = $urandom;
                    exp_q.push_back(mk(4'(1 << cur), 2'(cur), 1'b1, din[32*cur +: 32]));
                end else if (k < 9) begin
                    exp_q.push_back(mk(4'b0000, 2'(nxt), 1'b1, 32'hFFFF_FFFF));
                end else if (k == 9) begin
                    exp_q.push_back(mk(4'(1 << nxt), 2'(nxt), 1'b1, din[32*nxt +: 32]));
                end else begin
                    break;
                end
                tick();
                e = exp_q.pop_front();
                n_tests++;
                if (gnt !== e.gnt || {d3, d2, d1, d0} !== e.d || (e.chk_owner && owner !== e.owner)) begin
                    n_fail++;
                    $display("FAIL preempt round %0d cyc %0d: got gnt=%b d=%h owner=%0d, want gnt=%b d=%h owner=%0d",
                             r, k, gnt, {d3, d2, d1, d0}, owner, e.gnt, e.d, e.owner);
                end
            end
            cur = nxt;
        end
    endtask

    // Owner 1 releases with dwell still at 5; requester 3 takes over.
    task automatic test_release();
        din[127:96] = 32'h99B0A4F9;
        for (int k = 0; k < 5; k++) begin
            if (k < 2) begin
                exp_q.push_back(mk(4'b0010, 2'd1, 1'b1, din[63:32]));
            end else begin
                req = 4'b1000;
                if (k < 4) exp_q.push_back(mk(4'b0000, 2'd3, 1'b1, 32'hFFFF_FFFF));
                else       exp_q.push_back(mk(4'b1000, 2'd3, 1'b1, din[127:96]));
            end
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (gnt !== e.gnt || {d3, d2, d1, d0} !== e.d || (e.chk_owner && owner !== e.owner)) begin
                n_fail++;
                $display("FAIL release cyc %0d: got gnt=%b d=%h owner=%0d, want gnt=%b d=%h owner=%0d",
                         k, gnt, {d3, d2, d1, d0}, owner, e.gnt, e.d, e.owner);
            end
        end
    endtask

    // Owner 3 hands to 0 (pointer wrap), 0 then holds alone past dwell,
    // then a one-edge reset mid-OWN.
    task automatic test_sole_and_reset();
        din[31:0] = 32'h8080_8080;
        req = 4'b0001;
        for (int k = 0; k < 55; k++) begin
            if (k < 2)       exp_q.push_back(mk(4'b0000, 2'd0, 1'b1, 32'hFFFF_FFFF));
            else if (k < 53) exp_q.push_back(mk(4'b0001, 2'd0, 1'b1, din[31:0]));
            else begin
                reset_n = (k == 53) ? 1'b0 : 1'b1;
                if (k == 54) req = 4'b0000;
                exp_q.push_back(mk(4'b0000, 2'd0, 1'b1, 32'hFFFF_FFFF));
            end
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (gnt !== e.gnt || {d3, d2, d1, d0} !== e.d || (e.chk_owner && owner !== e.owner)) begin
                n_fail++;
                $display("FAIL sole_reset cyc %0d: got gnt=%b d=%h owner=%0d, want gnt=%b d=%h owner=%0d",
                         k, gnt, {d3, d2, d1, d0}, owner, e.gnt, e.d, e.owner);
            end
        end
    endtask

    // Pending owner drops during blanking: re-pick adds another gap; then a
    // pending owner drops with nobody else asking and the arbiter idles.
    task automatic test_repick();
        din[95:64] = 32'hF9F9_A4A4;
        req = 4'b0110;
        for (int k = 0; k < 12; k++) begin
            case (k)
                0:  exp_q.push_back(mk(4'b0000, 2'd1, 1'b1, 32'hFFFF_FFFF));
                1:  begin req = 4'b0100; exp_q.push_back(mk(4'b0000, 2'd1, 1'b1, 32'hFFFF_FFFF)); end
                2, 3: exp_q.push_back(mk(4'b0000, 2'd2, 1'b1, 32'hFFFF_FFFF));
                4:  exp_q.push_back(mk(4'b0100, 2'd2, 1'b1, din[95:64]));
                5:  begin req = 4'b0000; exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 32'hFFFF_FFFF)); end
                6:  begin req = 4'b0001; exp_q.push_back(mk(4'b0000, 2'd0, 1'b1, 32'hFFFF_FFFF)); end
                7:  begin req = 4'b0000; exp_q.push_back(mk(4'b0000, 2'd0, 1'b1, 32'hFFFF_FFFF)); end
                8, 9: exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 32'hFFFF_FFFF));
                10: begin req = 4'b0010; exp_q.push_back(mk(4'b0000, 2'd1, 1'b1, 32'hFFFF_FFFF)); end
                default: exp_q.push_back(mk(4'b0000, 2'd1, 1'b1, 32'hFFFF_FFFF));
            endcase
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (gnt !== e.gnt || {d3, d2, d1, d0} !== e.d || (e.chk_owner && owner !== e.owner)) begin
                n_fail++;
                $display("FAIL repick cyc %0d: got gnt=%b d=%h owner=%0d, want gnt=%b d=%h owner=%0d",
                         k, gnt, {d3, d2, d1, d0}, owner, e.gnt, e.d, e.owner);
            end
        end
        req = 4'b0000;
    endtask

`ifdef DISP_ARB_LOCK_EN
    // Locked owner 1 holds past dwell against requester 3, then yields.
    task automatic test_lock();
        reset_n = 1'b0;
        req     = 4'b0000;
        lock    = 4'b0000;
        tick();
        reset_n = 1'b1;
        din[63:32] = 32'hA4A4_B0B0;
        req = 4'b0010;
        for (int k = 0; k < 36; k++) begin
            if (k < 2)       exp_q.push_back(mk(4'b0000, 2'd1, 1'b1, 32'hFFFF_FFFF));
            else if (k < 33) begin
                if (k == 3) begin req = 4'b1010; lock = 4'b0010; end
                exp_q.push_back(mk(4'b0010, 2'd1, 1'b1, din[63:32]));
            end else begin
                lock = 4'b0000;
                if (k < 35) exp_q.push_back(mk(4'b0000, 2'd3, 1'b1, 32'hFFFF_FFFF));
                else        exp_q.push_back(mk(4'b1000, 2'd3, 1'b1, din[127:96]));
            end
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (gnt !== e.gnt || {d3, d2, d1, d0} !== e.d || (e.chk_owner && owner !== e.owner)) begin
                n_fail++;
                $display("FAIL lock cyc %0d: got gnt=%b d=%h owner=%0d, want gnt=%b d=%h owner=%0d",
                         k, gnt, {d3, d2, d1, d0}, owner, e.gnt, e.d, e.owner);
            end
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        req     = 4'b0000;
        din     = {32'h99B0A4F9, 32'hC0F9A4B0, 32'hF9F9F9F9, 32'hC0C0C0C0};
`ifdef DISP_ARB_LOCK_EN
        lock    = 4'b0000;
`endif
        test_reset();
        test_first_grant();
        test_preempt();
        test_release();
        test_sole_and_reset();
        test_repick();
`ifdef DISP_ARB_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
